io_controller: RTL and testbench
================================

Name: io_controller

Overview:
- Memory-mapped controller that sequences CPU accesses to the board I/O (switches in, LEDs out) for mother_board.
- Synchronizes and debounces the raw switch inputs and latches per-bit change flags.
- Owns the LED output register.
- Serializes one request at a time through an IDLE/ACCESS/RESPOND state machine with valid/ready handshakes on both the request and response sides.

Parameters:
- WIDTH, 4, number of switches and LEDs (io_bus width).
- DATA_WIDTH, 8, CPU data width; WIDTH-bit values are zero-extended on reads and truncated on writes. Must be >= WIDTH.
- DEBOUNCE_CYCLES, 3, number of consecutive identical synchronized samples required before the debounced switch bit updates. Must be >= 1.

Ports:
- clk  input  1  system clock (ctrl_bus clock).
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  CPU request present.
- req_ready  output  1  controller accepts the request this cycle.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  2  register select.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  CPU accepts the response.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
- rsp_err  output  1  write to a read-only address.
- switch_in  input  WIDTH  raw asynchronous switch pins.
- led_out  output  WIDTH  LED drive (registered).
- sw_event  output  1  OR of all change flags (interrupt-style level).

Behaviour:
- Reset is synchronous and active-high; it is sampled on the rising edge of clk and overrides all other activity, including a request mid-transaction.
- Reset values:
  - state = IDLE; req_ready = 0; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0.
  - led_out = 0; change flags = 0; sw_event = 0.
  - Debounced switch value = 0; sync flops = 0; debounce counters = 0.
  - Any in-flight request is dropped with no response.

Register map (by req_addr):
- 0 LED: R/W. A write sets led_out to req_wdata[WIDTH-1:0].
- 1 SWITCH: RO, debounced value. A write has no effect and sets rsp_err = 1.
- 2 FLAGS: read returns the change flags. Write-1-to-clear per bit.
- 3 TOGGLE: write XORs req_wdata[WIDTH-1:0] into led_out. A read returns 0 with rsp_err = 0.

State machine:
- IDLE:
  - req_ready = 1 (combinational, state-based only; no dependency on req_valid).
  - On req_valid & req_ready, capture write/addr/wdata and go to ACCESS.
- ACCESS (1 cycle):
  - req_ready = 0.
  - Perform the register read/write, register rsp_rdata and rsp_err, then go to RESPOND.
  - Register updates (led_out, flag clears) become visible on the edge leaving ACCESS.
- RESPOND:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake.

Latency:
- Accept edge to rsp_valid high: 2 cycles.
- Minimum throughput: one transaction per 3 cycles.

Switch path, per bit:
- Two-flop synchronizer.
- Counter increments while the synchronized value differs from the debounced value; it resets to 0 when they match.
- When the counter reaches DEBOUNCE_CYCLES, the debounced bit flips and the counter returns to 0.
- A glitch shorter than DEBOUNCE_CYCLES samples is ignored.
- The counter saturates logic and has no wrap-around: its width is clog2(DEBOUNCE_CYCLES+1).

Change flags:
- A flag bit sets on the cycle the debounced bit flips, in either direction.
- A flag clears only via a FLAGS write with a 1 in that bit.
- If set and clear occur in the same cycle, set wins.
- sw_event = |flags, registered with the flags.

A SWITCH read in ACCESS returns the debounced value as of that cycle.

Decomposition:
- Shared package io_pkg contains:
  - typedef io_state_t {IDLE, ACCESS, RESPOND};
  - address constants ADDR_LED = 0, ADDR_SWITCH = 1, ADDR_FLAGS = 2, ADDR_TOGGLE = 3.
- Sub-module io_debouncer (parameters WIDTH, DEBOUNCE_CYCLES):
  - contains the synchronizer and counters;
  - outputs the debounced value and a one-cycle per-bit flip pulse.
- io_controller instantiates one io_debouncer and holds the FSM, LED register and flags.

Test Plan:
- Reset, then write addr 0 data 8'h0A -> req_ready high in IDLE, rsp_valid exactly 2 cycles after accept, led_out = 4'hA, rsp_rdata = 0, rsp_err = 0.
- With led_out = 4'hA, write addr 3 data 8'h0F -> led_out = 4'h5. Then read addr 0 -> rsp_rdata = 8'h05.
- Drive switch_in = 4'b0001 steadily -> debounced bit 0 flips 2 (sync) + 3 cycles later, flag bit 0 set, sw_event = 1. A read of addr 1 returns 8'h01 and a read of addr 2 returns 8'h01.
- A pulse of switch_in[1] lasting 2 cycles -> no debounced change, flags stay 0.
- Write addr 2 data 8'h01 in the same cycle that bit 0 flips again -> flag bit 0 remains 1 (set wins). A later clear write of 8'h01 -> flags = 0, sw_event = 0.
- Write addr 1 -> rsp_err = 1, switches unchanged.
- Hold rsp_ready = 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0.
- Assert rst while in RESPOND -> next cycle rsp_valid = 0, led_out = 0, state IDLE.

Source files
------------

// File: rtl/io_pkg.sv
// Shared types and register map for the board I/O controller.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } io_state_t;

  localparam logic [1:0] ADDR_LED    = 2'd0;
  localparam logic [1:0] ADDR_SWITCH = 2'd1;
  localparam logic [1:0] ADDR_FLAGS  = 2'd2;
  localparam logic [1:0] ADDR_TOGGLE = 2'd3;

endpackage

// File: rtl/io_debouncer.sv
// Per-bit two-flop synchronizer and saturating debounce counter.
// The debounced bit flips after DEBOUNCE_CYCLES consecutive differing samples.
module io_debouncer #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] deb_out,
  output logic [WIDTH-1:0] flip_out
);

  localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] flip_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  always_comb begin
    deb_d  = deb_q;
    flip_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        // The current sample is the DEBOUNCE_CYCLES-th differing one.
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i]  = ~deb_q[i];
          flip_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign deb_out  = deb_q;
  assign flip_out = flip_d;

endmodule

// File: rtl/io_controller.sv
// Memory-mapped switch/LED controller: one request at a time through
// IDLE -> ACCESS -> RESPOND with valid/ready on both sides.
module io_controller
  import io_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  input  logic [WIDTH-1:0]      switch_in,
  output logic [WIDTH-1:0]      led_out,
  output logic                  sw_event
);

  io_state_t             state_q, state_d;
  logic                  wr_q, wr_d;
  logic [1:0]            addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [WIDTH-1:0]      led_q, led_d;
  logic [WIDTH-1:0]      flags_q, flags_d;
  logic                  evt_q, evt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [WIDTH-1:0]      clr;
  logic [WIDTH-1:0]      deb_val;
  logic [WIDTH-1:0]      deb_flip;
  logic                  unused_wdata;

  // Only the low WIDTH bits of write data are meaningful.
  assign unused_wdata = ^req_wdata;

  io_debouncer #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .rst      (rst),
    .raw_in   (switch_in),
    .deb_out  (deb_val),
    .flip_out (deb_flip)
  );

  assign req_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    led_d   = led_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata[WIDTH-1:0];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = RESPOND;
        case (addr_q)
          ADDR_LED: begin
            if (wr_q) led_d = wdata_q;
            else      rdata_d = DATA_WIDTH'(led_q);
          end
          ADDR_SWITCH: begin
            if (wr_q) err_d = 1'b1;
            else      rdata_d = DATA_WIDTH'(deb_val);
          end
          ADDR_FLAGS: begin
            if (wr_q) clr = wdata_q;
            else      rdata_d = DATA_WIDTH'(flags_q);
          end
          default: begin
            if (wr_q) led_d = led_q ^ wdata_q;
          end
        endcase
      end
      RESPOND: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A flip landing on the same edge as a clear keeps the flag set.
    flags_d = (flags_q & ~clr) | deb_flip;
    evt_d   = |flags_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      led_q   <= '0;
      flags_q <= '0;
      evt_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      led_q   <= led_d;
      flags_q <= flags_d;
      evt_q   <= evt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = (state_q == RESPOND);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign led_out   = led_q;
  assign sw_event  = evt_q;

endmodule

// File: tb/tb_io_controller.sv
// Scoreboard bench for io_controller: requests push expected responses,
// a monitor pops and compares on every response handshake.
module tb_io_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [3:0] switch_in;
  logic [3:0] led_out;
  logic       sw_event;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [8:0]  exp_q [$];

  io_controller #(
    .WIDTH           (4),
    .DATA_WIDTH      (8),
    .DEBOUNCE_CYCLES (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .switch_in (switch_in),
    .led_out   (led_out),
    .sw_event  (sw_event)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got rdata %0h err %0b expected no response", rsp_rdata, rsp_err);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e[7:0]);
          chk("rsp_err", rsp_err, e[8]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Issue one request; hold=1 keeps rsp_ready low for 5 cycles in RESPOND.
  task automatic do_req(input logic w, input logic [1:0] a, input logic [7:0] d,
                        input logic [7:0] er, input logic ee, input logic hold);
    int unsigned n;
    @(posedge clk); #1;
    if (hold) rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", req_ready, 1);
    exp_q.push_back({ee, er});
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("lat_access_no_valid", rsp_valid, 0);
    chk("req_ready_access", req_ready, 0);
    @(negedge clk);
    chk("lat_respond_valid", rsp_valid, 1);
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_rdata", rsp_rdata, er);
        chk("hold_err", rsp_err, ee);
        chk("hold_req_ready", req_ready, 0);
        @(negedge clk);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
    end
    n = 0;
    while (rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_done", rsp_valid, 0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    switch_in = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_led", led_out, 0);
    chk("rst_sw_event", sw_event, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);

    // LED write, toggle, readback
    do_req(1'b1, 2'd0, 8'h0A, 8'h00, 1'b0, 1'b0);
    chk("led_after_write", led_out, 4'hA);
    do_req(1'b1, 2'd3, 8'h0F, 8'h00, 1'b0, 1'b0);
    chk("led_after_toggle", led_out, 4'h5);
    do_req(1'b0, 2'd0, 8'h00, 8'h05, 1'b0, 1'b0);
    do_req(1'b0, 2'd3, 8'h00, 8'h00, 1'b0, 1'b0);
    do_req(1'b0, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0);
    do_req(1'b0, 2'd2, 8'h00, 8'h00, 1'b0, 1'b0);

    // Steady switch bit 0: flips on the 5th edge after the pin changes
    @(posedge clk); #1;
    switch_in = 4'b0001;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sw_event_before_flip", sw_event, 0);
    @(negedge clk);
    chk("sw_event_after_flip", sw_event, 1);
    do_req(1'b0, 2'd1, 8'h00, 8'h01, 1'b0, 1'b0);
    do_req(1'b0, 2'd2, 8'h00, 8'h01, 1'b0, 1'b0);

    // Two-cycle glitch on bit 1 is rejected
    @(posedge clk); #1;
    switch_in = 4'b0011;
    repeat (2) @(posedge clk);
    #1;
    switch_in = 4'b0001;
    repeat (8) @(posedge clk);
    do_req(1'b0, 2'd1, 8'h00, 8'h01, 1'b0, 1'b0);
    do_req(1'b0, 2'd2, 8'h00, 8'h01, 1'b0, 1'b0);

    // Clear of flag 0 lands on the same edge as bit 0 flipping back
    @(posedge clk); #1;
    switch_in = 4'b0000;
    repeat (2) @(posedge clk);
    do_req(1'b1, 2'd2, 8'h01, 8'h00, 1'b0, 1'b0);
    chk("set_wins_sw_event", sw_event, 1);
    do_req(1'b0, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0);
    do_req(1'b0, 2'd2, 8'h00, 8'h01, 1'b0, 1'b0);
    do_req(1'b1, 2'd2, 8'h01, 8'h00, 1'b0, 1'b0);
    chk("clear_sw_event", sw_event, 0);
    do_req(1'b0, 2'd2, 8'h00, 8'h00, 1'b0, 1'b0);

    // Write to read-only switch register
    do_req(1'b1, 2'd1, 8'hFF, 8'h00, 1'b1, 1'b0);
    chk("led_after_ro_write", led_out, 4'h5);
    do_req(1'b0, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0);

    // Back-pressure on the response
    do_req(1'b0, 2'd0, 8'h00, 8'h05, 1'b0, 1'b1);

    // Reset while in RESPOND drops the response
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 2'd0;
    req_wdata = 8'h03;
    @(negedge clk);
    chk("rstmid_req_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_in_respond", rsp_valid, 1);
    chk("rstmid_led_written", led_out, 4'h3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_rsp_valid", rsp_valid, 0);
    chk("rstmid_led", led_out, 0);
    chk("rstmid_sw_event", sw_event, 0);
    chk("rstmid_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rst       = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rstmid_idle_ready", req_ready, 1);
    do_req(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
